// File: rtl/l2_mem_pkg.sv
// Shared definitions for the L2 line <-> narrow word memory boundary.
// Provides the responder state encoding, line/word packing constants and a
// helper that extracts word k (bits [32k+31:32k]) from a 128-bit line.
package l2_mem_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
  localparam int unsigned BEAT_W     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRBeat,
    StWBeat,
    StDone
  } l2_mem_state_e;

  // Word 'beat' of a line; the word address on the narrow port is {line, beat}.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [BEAT_W-1:0] beat);
    return line[WORD_W * beat +: WORD_W];
  endfunction

endpackage

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 cache line port.
// Accepts one line read or write per request, serializes it into four word
// beats (order 0..3) on the narrow RAM port, then pulses mem_ready_o for one
// cycle. All outputs are registered.
//
// Ports:
//   clk_i, proc_reset_ni          clock, asynchronous active-low reset
//   mem_read_i, mem_write_i       level line requests, held until mem_ready_o
//   mem_addr_i, mem_wdata_i       line address / write line
//   mem_rdata_o, mem_ready_o      read line / one-cycle completion pulse
//   ram_req_o, ram_we_o           beat request / beat is a write
//   ram_addr_o, ram_wdata_o       word address {line, beat} / write word
//   ram_rdata_i, ram_ack_i        read word / beat complete
//   proto_err_o                   sticky: read and write both high at accept
module l2_mem_responder
  import l2_mem_pkg::*;
#(
  parameter int unsigned LINE_AW = 28
) (
  input  logic                 clk_i,
  input  logic                 proc_reset_ni,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [LINE_AW-1:0]   mem_addr_i,
  input  logic [LINE_W-1:0]    mem_wdata_i,
  output logic [LINE_W-1:0]    mem_rdata_o,
  output logic                 mem_ready_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [LINE_AW+1:0]   ram_addr_o,
  output logic [WORD_W-1:0]    ram_wdata_o,
  input  logic [WORD_W-1:0]    ram_rdata_i,
  input  logic                 ram_ack_i,
  output logic                 proto_err_o
);

  l2_mem_state_e        state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [LINE_AW-1:0]   line_q, line_d;
  logic [LINE_W-1:0]    wline_q, wline_d;
  logic [LINE_W-1:0]    rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [LINE_AW+1:0]   raddr_q, raddr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 perr_q, perr_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wline_d = wline_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    perr_d  = perr_q;

    unique case (state_q)
      StIdle: begin
        // Write wins when both requests are high; that case is flagged.
        if (mem_write_i) begin
          state_d = StWBeat;
          beat_d  = '0;
          line_d  = mem_addr_i;
          wline_d = mem_wdata_i;
          req_d   = 1'b1;
          we_d    = 1'b1;
          raddr_d = {mem_addr_i, 2'd0};
          wdata_d = line_word(mem_wdata_i, 2'd0);
          if (mem_read_i) begin
            perr_d = 1'b1;
          end
        end else if (mem_read_i) begin
          state_d = StRBeat;
          beat_d  = '0;
          line_d  = mem_addr_i;
          req_d   = 1'b1;
          we_d    = 1'b0;
          raddr_d = {mem_addr_i, 2'd0};
        end
      end
      StRBeat, StWBeat: begin
        if (ram_ack_i) begin
          if (state_q == StRBeat) begin
            rdata_d[WORD_W * beat_q +: WORD_W] = ram_rdata_i;
          end
          if (beat_q == 2'd3) begin
            state_d = StDone;
            req_d   = 1'b0;
            we_d    = 1'b0;
            ready_d = 1'b1;
          end else begin
            // Address/data advance only on the edge that retires a beat.
            beat_d  = beat_q + 2'd1;
            raddr_d = {line_q, beat_d};
            wdata_d = line_word(wline_q, beat_d);
          end
        end
      end
      StDone: begin
        // Request still high here is the finished one; ignore it.
        state_d = StIdle;
        beat_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge proc_reset_ni) begin
    if (!proc_reset_ni) begin
      state_q <= StIdle;
      beat_q  <= '0;
      line_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
    end
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = ready_q;
  assign ram_req_o   = req_q;
  assign ram_we_o    = we_q;
  assign ram_addr_o  = raddr_q;
  assign ram_wdata_o = wdata_q;
  assign proto_err_o = perr_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: a word-memory model answers beats,
// a line-level reference memory predicts beats and read lines.
module tb_l2_mem_responder;

  localparam int unsigned LINE_AW = 28;

  logic                clk_i = 1'b0;
  logic                proc_reset_ni;
  logic                mem_read_i, mem_write_i;
  logic [LINE_AW-1:0]  mem_addr_i;
  logic [127:0]        mem_wdata_i;
  logic [127:0]        mem_rdata_o;
  logic                mem_ready_o;
  logic                ram_req_o, ram_we_o;
  logic [LINE_AW+1:0]  ram_addr_o;
  logic [31:0]         ram_wdata_o;
  logic [31:0]         ram_rdata_i;
  logic                ram_ack_i;
  logic                proto_err_o;

  always #5 clk_i = ~clk_i;

  l2_mem_responder #(.LINE_AW(LINE_AW)) dut (
    .clk_i        (clk_i),
    .proc_reset_ni(proc_reset_ni),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_rdata_o  (mem_rdata_o),
    .mem_ready_o  (mem_ready_o),
    .ram_req_o    (ram_req_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i),
    .ram_ack_i    (ram_ack_i),
    .proto_err_o  (proto_err_o)
  );

  typedef struct {
    bit          we;
    logic [29:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t        exp_beats[$];
  logic [127:0] exp_resp[$];
  logic [31:0]  ram_mem[logic [29:0]];
  logic [31:0]  ref_mem[logic [29:0]];

  int           checks = 0;
  int           errors = 0;
  int           wait_mode = 0;   // <0: random 0..2 wait states per beat
  int           wait_total = 0;
  logic [127:0] last_rdata = '0;
  bit           prev_ready = 1'b0;

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [29:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_ready"}, mem_ready_o, 0);
    check({tag, "_ram_req"}, ram_req_o, 0);
    check({tag, "_ram_we"}, ram_we_o, 0);
    check({tag, "_proto_err"}, proto_err_o, 0);
    check({tag, "_mem_rdata"}, mem_rdata_o, 0);
    check({tag, "_ram_addr"}, ram_addr_o, 0);
    check({tag, "_ram_wdata"}, ram_wdata_o, 0);
  endtask

  // Word-memory model: acks each beat after a chosen number of wait cycles.
  initial begin : ram_side
    int  wait_left;
    bit  in_beat;
    beat_t b;
    ram_ack_i   = 1'b0;
    ram_rdata_i = '0;
    in_beat     = 1'b0;
    wait_left   = 0;
    forever begin
      @(negedge clk_i);
      ram_ack_i = 1'b0;
      if (ram_req_o && proc_reset_ni) begin
        if (!in_beat) begin
          in_beat   = 1'b1;
          wait_left = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
        end
        if (wait_left == 0) begin
          in_beat = 1'b0;
          ram_ack_i = 1'b1;
          check("beat_expected", exp_beats.size() != 0, 1);
          if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            check("beat_we", ram_we_o, b.we);
            check("beat_addr", ram_addr_o, b.addr);
            if (b.we) begin
              check("beat_wdata", ram_wdata_o, b.data);
            end
          end
          if (ram_we_o) begin
            ram_mem[ram_addr_o] = ram_wdata_o;
          end else begin
            ram_rdata_i = ram_rd(ram_addr_o);
          end
        end else begin
          wait_left--;
          wait_total++;
        end
      end else begin
        in_beat = 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk_i) begin
    if (prev_ready) begin
      check("ready_one_cycle", mem_ready_o, 0);
    end
    if (mem_ready_o) begin
      check("done_ram_req_low", ram_req_o, 0);
      check("resp_expected", exp_resp.size() != 0, 1);
      if (exp_resp.size() != 0) begin
        check("mem_rdata", mem_rdata_o, exp_resp.pop_front());
      end
    end
    prev_ready = mem_ready_o;
  end

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the IDLE
  // cycle after DONE with requests dropped, so calls chain back-to-back.
  task automatic do_txn(input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] wd, output int lat);
    beat_t        b;
    logic [127:0] rl;
    mem_read_i  = rd;
    mem_write_i = wr;
    mem_addr_i  = a;
    mem_wdata_i = wd;
    rl = '0;
    for (int k = 0; k < 4; k++) begin
      b.we   = wr;
      b.addr = {a, 2'b00} + 30'(k);
      b.data = wr ? wd[32*k +: 32] : 32'h0;
      exp_beats.push_back(b);
      if (wr) begin
        ref_mem[b.addr] = b.data;
      end else begin
        rl[32*k +: 32] = ref_rd(b.addr);
      end
    end
    if (!wr) begin
      last_rdata = rl;
    end
    exp_resp.push_back(last_rdata);
    wait_total = 0;
    lat = 0;
    @(negedge clk_i);
    while (!mem_ready_o) begin
      lat++;
      if (lat > 400) begin
        $display("FAIL ready_timeout actual=none required=mem_ready");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
      end
      @(negedge clk_i);
    end
    check("latency", lat, 5 + wait_total);
    @(posedge clk_i);
    #1;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int           lat;
    int           n;
    bit           rd;
    logic [27:0]  a;
    logic [127:0] wd;
    beat_t        b;

    proc_reset_ni = 1'b0;
    mem_read_i    = 1'b0;
    mem_write_i   = 1'b0;
    mem_addr_i    = '0;
    mem_wdata_i   = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    proc_reset_ni = 1'b1;
    @(negedge clk_i);
    check_outputs_zero("reset");
    @(posedge clk_i);
    #1;

    // Zero-wait read of line 0x123.
    wait_mode = 0;
    ram_mem[30'h48C] = 32'h11; ref_mem[30'h48C] = 32'h11;
    ram_mem[30'h48D] = 32'h22; ref_mem[30'h48D] = 32'h22;
    ram_mem[30'h48E] = 32'h33; ref_mem[30'h48E] = 32'h33;
    ram_mem[30'h48F] = 32'h44; ref_mem[30'h48F] = 32'h44;
    do_txn(1'b1, 1'b0, 28'h0000123, '0, lat);
    check("read0_latency", lat, 5);
    check("read0_rdata_hold", mem_rdata_o, 128'h00000044_00000033_00000022_00000011);

    // Write with two wait states per beat.
    wait_mode = 2;
    do_txn(1'b0, 1'b1, 28'h0ABCDEF, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, lat);
    check("write0_latency", lat, 13);
    check("write0_rdata_unchanged", mem_rdata_o, 128'h00000044_00000033_00000022_00000011);

    // Write-back immediately followed by read of the same line.
    wait_mode = 0;
    wd = {$urandom, $urandom, $urandom, $urandom};
    do_txn(1'b0, 1'b1, 28'h0000777, wd, lat);
    do_txn(1'b1, 1'b0, 28'h0000777, '0, lat);
    check("wbrd_readback", mem_rdata_o, wd);
    check("wbrd_beats_drained", exp_beats.size(), 0);
    check("proto_err_clear", proto_err_o, 0);

    // Randomized traffic over a small address pool.
    wait_mode = -1;
    for (int i = 0; i < 25; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 28'h0100000 + 28'($urandom_range(0, 7));
      wd = {$urandom, $urandom, $urandom, $urandom};
      do_txn(rd, !rd, a, wd, lat);
    end
    check("proto_err_still_clear", proto_err_o, 0);

    // Both requests high: write executes, error is sticky.
    wd = {$urandom, $urandom, $urandom, $urandom};
    do_txn(1'b1, 1'b1, 28'h0100003, wd, lat);
    check("proto_err_set", proto_err_o, 1);
    for (int i = 0; i < 5; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 28'h0100000 + 28'($urandom_range(0, 7));
      wd = {$urandom, $urandom, $urandom, $urandom};
      do_txn(rd, !rd, a, wd, lat);
    end
    do_txn(1'b1, 1'b0, 28'h0100003, '0, lat);
    check("proto_err_sticky", proto_err_o, 1);

    // Reset during beat 2 of a read.
    wait_mode   = 0;
    mem_read_i  = 1'b1;
    mem_addr_i  = 28'h0000200;
    for (int k = 0; k < 4; k++) begin
      b.we   = 1'b0;
      b.addr = {28'h0000200, 2'b00} + 30'(k);
      b.data = '0;
      exp_beats.push_back(b);
    end
    n = 0;
    @(negedge clk_i);
    while (!(ram_req_o && ram_addr_o[1:0] == 2'd2)) begin
      n++;
      if (n > 50) begin
        $display("FAIL beat2_timeout actual=none required=beat2");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
      end
      @(negedge clk_i);
    end
    #2;
    proc_reset_ni = 1'b0;
    #1;
    check_outputs_zero("abort");
    mem_read_i = 1'b0;
    exp_beats.delete();
    last_rdata = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_outputs_zero("abort_hold");
    proc_reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    do_txn(1'b1, 1'b0, 28'h0000200, '0, lat);
    check("post_reset_latency", lat, 5);
    check("post_reset_rdata", mem_rdata_o,
          {init_word(30'h803), init_word(30'h802), init_word(30'h801), init_word(30'h800)});

    repeat (3) @(negedge clk_i);
    check("beats_drained", exp_beats.size(), 0);
    check("resps_drained", exp_resp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
